// File: rtl/fire_pkg.sv
// Shared types and helpers for the bias stages of every fire layer.
// Biases are stored sign-magnitude; arithmetic happens in two's complement.
package fire_pkg;

  localparam int BIAS_W        = 16;
  localparam int BIAS_SIGN_BIT = BIAS_W - 1;

  typedef logic [BIAS_W-1:0] bias_t;
  typedef logic [BIAS_W-1:0] act_t;

  // Negative zero (0x8000) naturally maps to 0 because -0 == 0.
  function automatic logic signed [BIAS_W:0] sm2tc(input bias_t b);
    logic signed [BIAS_W:0] mag;
    mag = {2'b00, b[BIAS_SIGN_BIT-1:0]};
    return b[BIAS_SIGN_BIT] ? -mag : mag;
  endfunction

endpackage

// File: rtl/squeeze_bias_relu_if.sv
// Accumulator-in / activation-out stream bundle for the squeeze bias stage.
// master = MAC side plus expand consumer, slave = the bias stage itself.
interface squeeze_bias_relu_if #(
  parameter int ACC_W = 32
);
  import fire_pkg::*;

  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_last;
  logic             acc_ready;
  act_t             out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output acc_data, acc_valid, acc_last, out_ready,
    input  acc_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  acc_data, acc_valid, acc_last, out_ready,
    output acc_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/squeeze_bias_relu_sat_relu16.sv
// ReLU plus positive saturation of a signed sum into a 16-bit sign-magnitude
// activation; the sign bit of the result is therefore always 0.
module sat_relu16
  import fire_pkg::*;
#(
  parameter int SUM_W = 25
) (
  input  logic signed [SUM_W-1:0] sum_i,
  output act_t                    act_o
);

  localparam logic signed [SUM_W-1:0] ACT_MAX = SUM_W'((1 << (BIAS_W - 1)) - 1);

  always_comb begin
    act_o = '0;
    if (sum_i[SUM_W-1] || (sum_i == '0)) begin
      act_o = '0;
    end else if (sum_i > ACT_MAX) begin
      act_o = {1'b0, {(BIAS_W-1){1'b1}}};
    end else begin
      act_o = {1'b0, sum_i[BIAS_W-2:0]};
    end
  end

endmodule

// File: rtl/squeeze_bias_relu.sv
// Squeeze-layer bias stage: rescale accumulator, add per-channel bias, ReLU,
// saturate. Two register stages with a skid-free valid/ready chain.
module squeeze_bias_relu
  import fire_pkg::*;
#(
  parameter int NUM_CH    = 32,
  parameter int ACC_W     = 32,
  parameter int ACC_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  bias_t [NUM_CH-1:0]        bias_mem,
  squeeze_bias_relu_if.slave        bus,
  output logic [$clog2(NUM_CH)-1:0] chan_idx,
  output logic                      sync_err
);

  localparam int              CH_W    = $clog2(NUM_CH);
  localparam int              SH_W    = ACC_W - ACC_SHIFT;
  localparam int              SUM_W   = SH_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic                    ready1, ready2, accept, atEnd, syncMiss, lastIn;
  logic                    v1_q, v1_d, last1_q, last1_d;
  logic signed [SH_W-1:0]  shifted1_q, shifted1_d;
  logic signed [BIAS_W:0]  bias1_q, bias1_d;
  logic                    v2_q, v2_d, last2_q, last2_d;
  act_t                    data2_q, data2_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic                    err_q, err_d;
  logic signed [SUM_W-1:0] sum;
  act_t                    actS2;
  logic                    unusedLowBits;

  assign ready2   = !v2_q || bus.out_ready;
  assign ready1   = !v1_q || ready2;
  assign accept   = bus.acc_valid && ready1;
  assign atEnd    = (chan_q == LAST_CH);
  assign syncMiss = (bus.acc_last != atEnd);
  // A misplaced acc_last is trusted over the counter so the pixel boundary follows the MAC.
  assign lastIn   = syncMiss ? bus.acc_last : atEnd;

  // The bits shifted out by the floor shift never reach the datapath.
  assign unusedLowBits = ^bus.acc_data[ACC_SHIFT-1:0];

  always_comb begin
    v1_d       = v1_q;
    last1_d    = last1_q;
    shifted1_d = shifted1_q;
    bias1_d    = bias1_q;
    if (ready1) begin
      v1_d = bus.acc_valid;
      if (bus.acc_valid) begin
        shifted1_d = bus.acc_data[ACC_W-1:ACC_SHIFT];
        bias1_d    = sm2tc(bias_mem[chan_q]);
        last1_d    = lastIn;
      end
    end
  end

  assign sum = {shifted1_q[SH_W-1], shifted1_q}
             + {{(SUM_W-BIAS_W-1){bias1_q[BIAS_W]}}, bias1_q};

  sat_relu16 #(.SUM_W(SUM_W)) u_satRelu (
    .sum_i (sum),
    .act_o (actS2)
  );

  always_comb begin
    v2_d    = v2_q;
    data2_d = data2_q;
    last2_d = last2_q;
    if (ready2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = actS2;
        last2_d = last1_q;
      end
    end
  end

  always_comb begin
    chan_d = chan_q;
    err_d  = err_q;
    if (accept) begin
      chan_d = (bus.acc_last || atEnd) ? '0 : chan_q + 1'b1;
      if (syncMiss) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      shifted1_q <= '0;
      bias1_q    <= '0;
      v2_q       <= 1'b0;
      data2_q    <= '0;
      last2_q    <= 1'b0;
      chan_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      last1_q    <= last1_d;
      shifted1_q <= shifted1_d;
      bias1_q    <= bias1_d;
      v2_q       <= v2_d;
      data2_q    <= data2_d;
      last2_q    <= last2_d;
      chan_q     <= chan_d;
      err_q      <= err_d;
    end
  end

  assign bus.acc_ready = ready1;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = data2_q;
  assign bus.out_last  = last2_q;
  assign chan_idx      = chan_q;
  assign sync_err      = err_q;

endmodule

// File: tb/tb_squeeze_bias_relu.sv
// Randomised bench for squeeze_bias_relu: a queue-based reference model is
// compared against the DUT every cycle, with directed pixel/backpressure/sync cases.
module tb_squeeze_bias_relu;
  import fire_pkg::*;

  localparam int NUM_CH    = 32;
  localparam int ACC_W     = 32;
  localparam int ACC_SHIFT = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  bias_t [NUM_CH-1:0]  biasMem;
  logic [4:0]          chanIdx;
  logic                syncErr;

  squeeze_bias_relu_if #(.ACC_W(ACC_W)) bus ();

  squeeze_bias_relu #(
    .NUM_CH    (NUM_CH),
    .ACC_W     (ACC_W),
    .ACC_SHIFT (ACC_SHIFT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bias_mem (biasMem),
    .bus      (bus),
    .chan_idx (chanIdx),
    .sync_err (syncErr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        monitorOn = 1'b0;
  logic        readyMode = 1'b0;
  logic        holdReady = 1'b1;
  logic [15:0] qData[$];
  logic        qLast[$];
  int          qCyc[$];
  int          modelCh = 0;
  logic        modelErr = 1'b0;
  logic [15:0] logData[$];
  logic        logLast[$];
  int          stallCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: floor-shift, add signed bias, clamp to [0, 32767].
  function automatic logic [15:0] refAct(input logic [31:0] acc, input logic [15:0] bias);
    longint a, b, s;
    a = longint'($signed(acc));
    a = a >>> ACC_SHIFT;
    b = longint'(bias[14:0]);
    if (bias[15]) b = -b;
    s = a + b;
    if (s <= 0) return 16'h0000;
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  function automatic logic [31:0] randAcc();
    int pick;
    pick = $urandom_range(0, 9);
    if (pick == 0) return $urandom;
    if (pick == 1) return 32'h7FFF_FFFF;
    if (pick == 2) return 32'h8000_0000;
    return 32'(int'($urandom_range(0, 20000000)) - 10000000);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = readyMode ? ($urandom_range(0, 3) != 0) : holdReady;
  end

  // Items become visible one cycle after capture; capacity is two beats.
  always @(negedge clk) begin
    logic expValid, expReady, atEnd, lastBit;
    if (monitorOn) begin
      expValid = (qData.size() > 0) && (qCyc[0] < cyc);
      expReady = !((qData.size() == 2) && !bus.out_ready);
      checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
      if (expValid) begin
        checkOutput("out_data", 32'(bus.out_data), 32'(qData[0]));
        checkOutput("out_last", 32'(bus.out_last), 32'(qLast[0]));
      end
      checkOutput("acc_ready", 32'(bus.acc_ready), 32'(expReady));
      checkOutput("chan_idx", 32'(chanIdx), 32'(modelCh));
      checkOutput("sync_err", 32'(syncErr), 32'(modelErr));
      if (bus.acc_valid && !bus.acc_ready) stallCount++;
      if (bus.out_valid && bus.out_ready) begin
        logData.push_back(bus.out_data);
        logLast.push_back(bus.out_last);
      end
      if (rst) begin
        qData.delete(); qLast.delete(); qCyc.delete();
        modelCh  = 0;
        modelErr = 1'b0;
      end else begin
        if (expValid && bus.out_ready) begin
          void'(qData.pop_front()); void'(qLast.pop_front()); void'(qCyc.pop_front());
        end
        if (bus.acc_valid && expReady) begin
          atEnd = (modelCh == NUM_CH - 1);
          if (bus.acc_last != atEnd) begin
            modelErr = 1'b1;
            lastBit  = bus.acc_last;
          end else begin
            lastBit = atEnd;
          end
          qData.push_back(refAct(bus.acc_data, biasMem[modelCh]));
          qLast.push_back(lastBit);
          qCyc.push_back(cyc + 1);
          modelCh = (bus.acc_last || atEnd) ? 0 : modelCh + 1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic l);
    int n = 0;
    bus.acc_data  = d;
    bus.acc_last  = l;
    bus.acc_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.acc_ready) break;
      n++;
      if (n > 200) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.acc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitLog(input int n);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (logData.size() < n && t < 500);
    checkOutput("log_count", 32'(logData.size()), 32'(n));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] px[NUM_CH];
    logic [15:0] bpExp[8];
    logic [31:0] d;
    int          base, lastCount, bpBase;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    bus.acc_last  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) biasMem[i] = {1'($urandom), 15'($urandom_range(0, 2000))};
    biasMem[0]  = 16'h802E;
    biasMem[1]  = 16'h0048;
    biasMem[5]  = 16'h8000;
    biasMem[12] = 16'h82A1;
    biasMem[13] = 16'h0280;

    checkOutput("model_ch1",     32'(refAct(32'h0000_1000, 16'h0048)), 32'h0058);
    checkOutput("model_ch0",     32'(refAct(32'h0000_1000, 16'h802E)), 32'h0000);
    checkOutput("model_ch12",    32'(refAct(32'h0003_E800, 16'h82A1)), 32'h0147);
    checkOutput("model_ch13",    32'(refAct(32'h0003_E800, 16'h0280)), 32'h0668);
    checkOutput("model_sat",     32'(refAct(32'h7FFF_FFFF, 16'h802E)), 32'h7FFF);
    checkOutput("model_neg",     32'(refAct(32'h8000_0000, 16'h7FFF)), 32'h0000);
    checkOutput("model_negzero", 32'(refAct(32'h0000_0500, 16'h8000)), 32'h0005);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 monitorOn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_acc_ready", 32'(bus.acc_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst_out_last",  32'(bus.out_last),  32'd0);
    checkOutput("rst_chan_idx",  32'(chanIdx),       32'd0);
    checkOutput("rst_sync_err",  32'(syncErr),       32'd0);

    $display("[TB] full pixel with directed channels");
    for (int i = 0; i < NUM_CH; i++) px[i] = randAcc();
    px[0]  = 32'h0000_1000;
    px[1]  = 32'h0000_1000;
    px[5]  = 32'h0000_0500;
    px[12] = 32'h0003_E800;
    px[13] = 32'h0003_E800;
    px[14] = 32'h7FFF_FFFF;
    px[15] = 32'h8000_0000;
    base = logData.size();
    for (int i = 0; i < NUM_CH; i++) applyStimulus(px[i], i == NUM_CH - 1);
    checkOutput("pixel_wrap_chan", 32'(chanIdx), 32'd0);
    applyStimulus(32'h0000_1000, 1'b0);
    waitLog(base + NUM_CH + 1);
    checkOutput("px_ch0",  32'(logData[base + 0]),  32'h0000);
    checkOutput("px_ch1",  32'(logData[base + 1]),  32'h0058);
    checkOutput("px_ch5",  32'(logData[base + 5]),  32'h0005);
    checkOutput("px_ch12", 32'(logData[base + 12]), 32'h0147);
    checkOutput("px_ch13", 32'(logData[base + 13]), 32'h0668);
    checkOutput("px_ch14", 32'(logData[base + 14]), 32'h7FFF);
    checkOutput("px_ch15", 32'(logData[base + 15]), 32'h0000);
    checkOutput("px_next_ch0", 32'(logData[base + NUM_CH]), 32'h0000);
    lastCount = 0;
    for (int i = 0; i < NUM_CH + 1; i++) lastCount += int'(logLast[base + i]);
    checkOutput("px_last_count", 32'(lastCount), 32'd1);
    checkOutput("px_last_pos",   32'(logLast[base + NUM_CH - 1]), 32'd1);
    checkOutput("px_sync_err",   32'(syncErr), 32'd0);

    $display("[TB] backpressure");
    base   = logData.size();
    bpBase = stallCount;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = randAcc();
          bpExp[i] = refAct(d, biasMem[1 + i]);
          applyStimulus(d, 1'b0);
        end
      end
      begin
        idle(3);
        holdReady = 1'b0;
        idle(5);
        holdReady = 1'b1;
      end
    join
    waitLog(base + 8);
    checkOutput("bp_stall_seen", 32'(stallCount > bpBase), 32'd1);
    for (int i = 0; i < 8; i++) checkOutput("bp_order", 32'(logData[base + i]), 32'(bpExp[i]));

    $display("[TB] sync error and mid-stream reset");
    pulseReset();
    base = logData.size();
    for (int i = 0; i < 11; i++) applyStimulus(randAcc(), i == 10);
    checkOutput("sync_err_set",  32'(syncErr), 32'd1);
    checkOutput("sync_resync",   32'(chanIdx), 32'd0);
    applyStimulus(32'h0000_1000, 1'b0);
    waitLog(base + 12);
    checkOutput("sync_last_bit", 32'(logLast[base + 10]), 32'd1);
    checkOutput("sync_ch0_bias", 32'(logData[base + 11]), 32'h0000);
    holdReady = 1'b0;
    idle(2);
    applyStimulus(randAcc(), 1'b0);
    applyStimulus(randAcc(), 1'b0);
    checkOutput("full_before_rst", 32'(bus.out_valid && !bus.acc_ready), 32'd1);
    pulseReset();
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_err",   32'(syncErr),       32'd0);
    checkOutput("mid_rst_chan",  32'(chanIdx),       32'd0);
    holdReady = 1'b1;
    idle(2);

    $display("[TB] random stream");
    readyMode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (i == 400) pulseReset();
      applyStimulus(randAcc(), (modelCh == NUM_CH - 1) ^ ($urandom_range(0, 49) == 0));
    end
    readyMode = 1'b0;
    holdReady = 1'b1;
    for (int t = 0; t < 200 && qData.size() > 0; t++) idle(1);
    checkOutput("drain_empty", 32'(qData.size()), 32'd0);
    idle(2);
    monitorOn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
